// File: rtl/add_round_key_stream_if.sv
// Stream bundle for the AddRoundKey stage: state beats in, XORed beats out.
// The slave view belongs to the stage; the master view belongs to whoever drives it.
interface add_round_key_stream_if #(
    parameter int DATA_W = 128,
    parameter int AW     = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AW-1:0]     in_round;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, in_round, out_ready,
        output in_ready, out_valid, out_data, out_last, out_err
    );

    modport master (
        output in_valid, in_data, in_round, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_err
    );
endinterface

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey: XORs each accepted beat with its round key from an internal
// table and queues the result in a 2-entry output FIFO with valid/ready handshakes.
module add_round_key_stream #(
    parameter int DATA_W     = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int CNT_W      = 16,
    localparam int AW        = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  key_wr_en,
    input  logic [AW-1:0]         key_wr_addr,
    input  logic [DATA_W-1:0]     key_wr_data,
    input  logic                  key_clr,
    add_round_key_stream_if.slave strm,
    output logic                  done_flag,
    output logic [CNT_W-1:0]      blk_cnt
);
    localparam logic [AW-1:0] LAST_R = AW'(NUM_ROUNDS);

    logic [DATA_W-1:0] key_q [NUM_ROUNDS+1];
    logic [NUM_ROUNDS:0] kv_q, kv_d;

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] h_data_q, t_data_q;
    logic              h_last_q, h_err_q, t_last_q, t_err_q;
    logic              done_q;
    logic [CNT_W-1:0]  blk_cnt_q;

    logic              wr_ok, rd_ok, hit, push, pop;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] res_data;
    logic              res_last, res_err;
    logic              load_head_new, load_head_tail, load_tail;

    assign wr_ok  = key_wr_en && (key_wr_addr <= LAST_R);
    assign rd_ok  = strm.in_round <= LAST_R;
    // Out-of-range rounds read entry 0 harmlessly; the result is flagged as an error anyway.
    assign rd_idx = rd_ok ? strm.in_round : '0;
    assign hit    = rd_ok && kv_q[rd_idx];

    assign res_data = hit ? (strm.in_data ^ key_q[rd_idx]) : strm.in_data;
    assign res_err  = !hit;
    assign res_last = (strm.in_round == LAST_R);

    assign strm.in_ready  = (cnt_q < 2'd2);
    assign strm.out_valid = (cnt_q != 2'd0);
    assign strm.out_data  = h_data_q;
    assign strm.out_last  = h_last_q;
    assign strm.out_err   = h_err_q;
    assign done_flag      = done_q;
    assign blk_cnt        = blk_cnt_q;

    assign push = strm.in_valid && strm.in_ready;
    assign pop  = strm.out_valid && strm.out_ready;

    // New beat goes straight to the head if the FIFO is empty or the head leaves this edge.
    assign load_head_new  = push && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
    assign load_head_tail = pop && (cnt_q == 2'd2);
    assign load_tail      = push && (cnt_q == 2'd1) && !pop;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        kv_d = key_clr ? '0 : kv_q;
        if (wr_ok) kv_d[key_wr_addr] = 1'b1;

        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            kv_q      <= '0;
            cnt_q     <= 2'd0;
            h_last_q  <= 1'b0;
            h_err_q   <= 1'b0;
            t_last_q  <= 1'b0;
            t_err_q   <= 1'b0;
            done_q    <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            kv_q   <= kv_d;
            cnt_q  <= cnt_d;
            done_q <= pop && h_last_q;
            if (pop && h_last_q && !h_err_q) blk_cnt_q <= blk_cnt_q + CNT_W'(1);

            if (load_head_new) begin
                h_last_q <= res_last;
                h_err_q  <= res_err;
            end else if (load_head_tail) begin
                h_last_q <= t_last_q;
                h_err_q  <= t_err_q;
            end
            if (load_tail) begin
                t_last_q <= res_last;
                t_err_q  <= res_err;
            end
        end
    end

    // NOTE: wide key/data storage is deliberately not reset; the reset valid bits and count make it unobservable.
    always_ff @(posedge CLK) begin
        if (wr_ok) key_q[key_wr_addr] <= key_wr_data;
        if (load_head_new)       h_data_q <= res_data;
        else if (load_head_tail) h_data_q <= t_data_q;
        if (load_tail) t_data_q <= res_data;
    end
endmodule
